// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - enable input and timing outputs of vga_timing_gen.
// The o_Frame_Count signal exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic       i_Enable;
  logic       o_HSync;
  logic       o_VSync;
  logic [9:0] o_Col_Count;
  logic [9:0] o_Row_Count;
  logic       o_Active;
  logic       o_Frame_Start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] o_Frame_Count;
`endif

  // master: the timing generator itself; slave: the video pipeline that consumes the timing.
  modport master (
    input  i_Enable,
    output o_HSync,
    output o_VSync,
    output o_Col_Count,
    output o_Row_Count,
    output o_Active,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output o_Frame_Count,
`endif
    output o_Frame_Start
  );

  modport slave (
    output i_Enable,
    input  o_HSync,
    input  o_VSync,
    input  o_Col_Count,
    input  o_Row_Count,
    input  o_Active,
`ifdef VGA_TIMING_FRAME_CNT_EN
    input  o_Frame_Count,
`endif
    input  o_Frame_Start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA column/row counters with registered sync, active and frame-start.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit wrapping o_Frame_Count output.
module vga_timing_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  vga_timing_gen_if.master bus
);

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HS_FIRST = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] HS_LAST  = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [9:0] VS_FIRST = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] VS_LAST  = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       frame_start_q, frame_start_d;

  // Decodes use the next counts so sync/active land in the same register stage as the counts.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    frame_start_d = 1'b0;
    if (bus.i_Enable) begin
      if (col_q == COL_LAST) begin
        col_d         = '0;
        row_d         = (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
        frame_start_d = (row_q == ROW_LAST);
      end else begin
        col_d = col_q + 10'd1;
      end
      hsync_d  = !((col_d >= HS_FIRST) && (col_d <= HS_LAST));
      vsync_d  = !((row_d >= VS_FIRST) && (row_d <= VS_LAST));
      active_d = (col_d < ACT_COLS) && (row_d < ACT_ROWS);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      col_q         <= '0;
      row_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.o_Col_Count   = col_q;
  assign bus.o_Row_Count   = row_q;
  assign bus.o_HSync       = hsync_q;
  assign bus.o_VSync       = vsync_q;
  assign bus.o_Active      = active_q;
  assign bus.o_Frame_Start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {7'd0, frame_start_d};
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.o_Frame_Count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a reduced raster.
// Frame-count checks are compiled in when VGA_TIMING_FRAME_CNT_EN is defined.
module tb_vga_timing_gen;
  localparam int TC  = 20;
  localparam int TR  = 10;
  localparam int AC  = 10;
  localparam int AR  = 6;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int F   = TC * TR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  // Reference model: linear pixel position within the frame plus bookkeeping.
  int p          = 0;
  bit rst_state  = 1'b1;
  bit fs_exp     = 1'b0;
  int frames_exp = 0;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (vif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit exp_hs();
    int c = p % TC;
    if (rst_state) return 1'b1;
    return !(c >= AC + HFP && c < AC + HFP + HSW);
  endfunction

  function automatic bit exp_vs();
    int r = p / TC;
    if (rst_state) return 1'b1;
    return !(r >= AR + VFP && r < AR + VFP + VSW);
  endfunction

  function automatic bit exp_act();
    if (rst_state) return 1'b0;
    return (p % TC) < AC && (p / TC) < AR;
  endfunction

  task automatic check_all();
    chk("col",         32'(vif.o_Col_Count),   32'(p % TC));
    chk("row",         32'(vif.o_Row_Count),   32'(p / TC));
    chk("hsync",       32'(vif.o_HSync),       32'(exp_hs()));
    chk("vsync",       32'(vif.o_VSync),       32'(exp_vs()));
    chk("active",      32'(vif.o_Active),      32'(exp_act()));
    chk("frame_start", 32'(vif.o_Frame_Start), 32'(fs_exp));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frame_count", 32'(vif.o_Frame_Count), 32'(frames_exp));
`endif
  endtask

  task automatic step(input bit r, input bit e);
    rst          = r;
    vif.i_Enable = e;
    @(posedge clk);
    if (r) begin
      p = 0; rst_state = 1'b1; fs_exp = 1'b0; frames_exp = 0;
    end else if (e) begin
      p = (p + 1) % F;
      rst_state = 1'b0;
      fs_exp = (p == 0);
      if (fs_exp) frames_exp = (frames_exp + 1) % 256;
    end else begin
      fs_exp = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    int fs_cnt, fs_at, hs_low0, act_row0, vs_low, act_all;
    vif.i_Enable = 1'b0;

    // Reset for 5 cycles with enable toggling; reset must win.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'(i % 2));
      chk("rst_col", 32'(vif.o_Col_Count), 0);
      chk("rst_hs",  32'(vif.o_HSync),     1);
      chk("rst_act", 32'(vif.o_Active),    0);
    end

    // First enabled edge after reset, then the rest of a full frame.
    step(1'b0, 1'b1);
    chk("first_col", 32'(vif.o_Col_Count),   1);
    chk("first_row", 32'(vif.o_Row_Count),   0);
    chk("first_act", 32'(vif.o_Active),      1);
    chk("first_fs",  32'(vif.o_Frame_Start), 0);
    fs_cnt = 0; fs_at = -1; hs_low0 = 0; act_row0 = 0; vs_low = 0; act_all = 0;
    for (int n = 1; n <= F; n++) begin
      if (n > 1) step(1'b0, 1'b1);
      if (vif.o_Frame_Start) begin fs_cnt++; fs_at = n; end
      if (vif.o_Row_Count == 0 && !vif.o_HSync) hs_low0++;
      if (vif.o_Row_Count == 0 && vif.o_Active) act_row0++;
      if (!vif.o_VSync) vs_low++;
      if (vif.o_Active) act_all++;
    end
    chk("fs_count",    32'(fs_cnt),   1);
    chk("fs_cycle",    32'(fs_at),    32'(F));
    chk("hs_low_line", 32'(hs_low0),  32'(HSW));
    chk("act_line",    32'(act_row0), 32'(AC));
    chk("vs_low_frm",  32'(vs_low),   32'(VSW * TC));
    chk("act_frame",   32'(act_all),  32'(AC * AR));

    // Freeze inside both sync pulses (col 13, row 7), then resume.
    for (int n = 0; n < F && p != 7 * TC + 13; n++) step(1'b0, 1'b1);
    chk("nav_pos", 32'(p), 32'(7 * TC + 13));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      chk("hold_col", 32'(vif.o_Col_Count), 13);
      chk("hold_row", 32'(vif.o_Row_Count), 7);
      chk("hold_hs",  32'(vif.o_HSync),     0);
      chk("hold_vs",  32'(vif.o_VSync),     0);
    end
    step(1'b0, 1'b1);
    chk("resume_col", 32'(vif.o_Col_Count), 14);

    // Reset while in sync pulse releases sync at once.
    step(1'b1, 1'b1);
    chk("mid_rst_col", 32'(vif.o_Col_Count), 0);
    chk("mid_rst_row", 32'(vif.o_Row_Count), 0);
    chk("mid_rst_hs",  32'(vif.o_HSync),     1);
    chk("mid_rst_vs",  32'(vif.o_VSync),     1);
    chk("mid_rst_act", 32'(vif.o_Active),    0);

    // Randomized enable with occasional reset against the model.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0));

`ifdef VGA_TIMING_FRAME_CNT_EN
    step(1'b1, 1'b0);
    for (int i = 0; i < 257 * F; i++) step(1'b0, 1'b1);
    chk("frame_cnt_wrap", 32'(vif.o_Frame_Count), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
